// File: rtl/ggt_sequencer.sv
// Batch sequencer for ggt_top: fetches operand pairs from a ROM, launches each gcd computation
// and writes the results to the result memory, with zero-operand bypass and a hang timeout.
module ggt_sequencer #(
   parameter int unsigned N_PAIRS     = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              run_i,
   output logic [ADDR_W-1:0] op_addr_o,
   input  logic [31:0]       op_data_i,
   output logic [15:0]       zahl1_o,
   output logic [15:0]       zahl2_o,
   output logic              ggt_start_o,
   input  logic              ggt_valid_i,
   input  logic [15:0]       ggt_ergebnis_i,
   output logic [ADDR_W-1:0] res_addr_o,
   output logic [15:0]       res_data_o,
   output logic              res_wren_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ADDR_W:0]   count_o
);

   localparam int unsigned       CntW     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(N_PAIRS - 1);
   localparam logic [CntW-1:0]   CountMax = CntW'(N_PAIRS);
   localparam logic [16:0]       WaitLast = 17'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle, StFetch, StLoad, StStart, StWait, StStore, StDone
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] op_addr_q;
   logic [15:0]       zahl1_q, zahl2_q;
   logic              start_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic [15:0]       res_data_q;
   logic              res_wren_q;
   logic              busy_q, done_q, error_q;
   logic [CntW-1:0]   count_q;
   logic [16:0]       wait_cnt_q;

   logic op_zero, valid_hit, timeout_hit;

   assign op_zero     = (op_data_i[31:16] == 16'd0) || (op_data_i[15:0] == 16'd0);
   // A zero count marks the first WAIT cycle, where valid may still be left over.
   assign valid_hit   = ggt_valid_i && (wait_cnt_q != 17'd0);
   assign timeout_hit = (wait_cnt_q == WaitLast);

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         op_addr_q  <= '0;
         zahl1_q    <= '0;
         zahl2_q    <= '0;
         start_q    <= 1'b0;
         res_addr_q <= '0;
         res_data_q <= '0;
         res_wren_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
         wait_cnt_q <= '0;
      end else begin
         start_q    <= 1'b0;
         res_wren_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (run_i) begin
                  idx_q     <= '0;
                  op_addr_q <= '0;
                  count_q   <= '0;
                  error_q   <= 1'b0;
                  done_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= StFetch;
               end
            end
            StFetch: state_q <= StLoad;
            StLoad: begin
               zahl1_q <= op_data_i[31:16];
               zahl2_q <= op_data_i[15:0];
               if (op_zero) begin
                  res_wren_q <= 1'b1;
                  res_addr_q <= idx_q;
                  res_data_q <= op_data_i[31:16] | op_data_i[15:0];
                  state_q    <= StStore;
               end else begin
                  start_q <= 1'b1;
                  state_q <= StStart;
               end
            end
            StStart: begin
               wait_cnt_q <= '0;
               state_q    <= StWait;
            end
            StWait: begin
               wait_cnt_q <= wait_cnt_q + 17'd1;
               if (valid_hit) begin
                  res_wren_q <= 1'b1;
                  res_addr_q <= idx_q;
                  res_data_q <= ggt_ergebnis_i;
                  state_q    <= StStore;
               end else if (timeout_hit) begin
                  res_wren_q <= 1'b1;
                  res_addr_q <= idx_q;
                  res_data_q <= 16'h0000;
                  error_q    <= 1'b1;
                  state_q    <= StStore;
               end
            end
            StStore: begin
               if (count_q != CountMax) begin
                  count_q <= count_q + 1'b1;
               end
               if (idx_q == LastIdx) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q     <= idx_q + 1'b1;
                  op_addr_q <= idx_q + 1'b1;
                  state_q   <= StFetch;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign op_addr_o   = op_addr_q;
   assign zahl1_o     = zahl1_q;
   assign zahl2_o     = zahl2_q;
   assign ggt_start_o = start_q;
   assign res_addr_o  = res_addr_q;
   assign res_data_o  = res_data_q;
   assign res_wren_o  = res_wren_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_ggt_sequencer.sv
// Self-checking bench for ggt_sequencer: ROM and ggt_top responder models plus a timeline model
// of the expected per-cycle outputs for each batch.
module tb_ggt_sequencer;

   localparam int NP  = 4;
   localparam int AW  = 3;
   localparam int TMO = 10;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          run_i = 1'b0;
   logic [AW-1:0] op_addr_o;
   logic [31:0]   op_data_i = '0;
   logic [15:0]   zahl1_o, zahl2_o;
   logic          ggt_start_o;
   logic          g_valid = 1'b0;
   logic [15:0]   g_erg = '0;
   logic [AW-1:0] res_addr_o;
   logic [15:0]   res_data_o;
   logic          res_wren_o;
   logic          busy_o, done_o, error_o;
   logic [AW:0]   count_o;

   ggt_sequencer #(.N_PAIRS(NP), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .run_i         (run_i),
      .op_addr_o     (op_addr_o),
      .op_data_i     (op_data_i),
      .zahl1_o       (zahl1_o),
      .zahl2_o       (zahl2_o),
      .ggt_start_o   (ggt_start_o),
      .ggt_valid_i   (g_valid),
      .ggt_ergebnis_i(g_erg),
      .res_addr_o    (res_addr_o),
      .res_data_o    (res_data_o),
      .res_wren_o    (res_wren_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   // Operand ROM with one cycle of read latency, and per-pair responder configuration.
   logic [31:0] rom [0:7];
   int          cfg_lat [0:7];
   bit          cfg_stuck [0:7];
   bit          cfg_stale [0:7];

   always @(posedge clk) op_data_i <= rom[op_addr_o];

   function automatic int gcd(input int a_in, input int b_in);
      int a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = b;
         b = a % b;
         a = t;
      end
      return a;
   endfunction

   // ggt_top stand-in: valid drops on start (unless stale mode), result appears after cfg_lat.
   logic        g_pend = 1'b0;
   int          g_lat = 0;
   logic [15:0] g_res = '0;
   always @(posedge clk) begin
      if (ggt_start_o) begin
         g_pend <= 1'b1;
         g_lat  <= cfg_lat[op_addr_o];
         g_res  <= 16'(gcd(int'(zahl1_o), int'(zahl2_o)));
         if (!cfg_stale[op_addr_o]) g_valid <= 1'b0;
      end else if (g_pend && !cfg_stuck[op_addr_o]) begin
         if (g_lat <= 1) begin
            g_valid <= 1'b1;
            g_erg   <= g_res;
            g_pend  <= 1'b0;
         end else begin
            g_lat <= g_lat - 1;
         end
      end
   end

   int wr_q[$];
   int n_starts = 0;
   always @(posedge clk) begin
      if (res_wren_o) wr_q.push_back(int'(res_data_o));
      if (ggt_start_o) n_starts <= n_starts + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int c, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, c, act, exp);
      end
   endtask

   task automatic set_pair(input int i, input int a, input int b, input int lat, input bit stuck,
                           input bit stale);
      rom[i]       = {a[15:0], b[15:0]};
      cfg_lat[i]   = lat;
      cfg_stuck[i] = stuck;
      cfg_stale[i] = stale;
   endtask

   // Expected timeline, cycle 0 = first cycle after run_i is sampled.
   int m_ps [NP];
   int m_st [NP];
   int m_store [NP];
   int m_data [NP];
   bit m_to [NP];

   function automatic int build_model();
      int s, a, b, k;
      s = 0;
      for (int i = 0; i < NP; i++) begin
         a = int'(rom[i][31:16]);
         b = int'(rom[i][15:0]);
         m_ps[i] = s;
         m_to[i] = 1'b0;
         if (a == 0 || b == 0) begin
            m_st[i]    = -1;
            m_data[i]  = a | b;
            m_store[i] = s + 2;
         end else begin
            m_st[i] = s + 2;
            if (cfg_stuck[i] || cfg_lat[i] + 1 > TMO) begin
               k         = TMO;
               m_data[i] = 0;
               m_to[i]   = 1'b1;
            end else begin
               k         = cfg_lat[i] + 1;
               m_data[i] = gcd(a, b);
            end
            m_store[i] = s + 3 + k;
         end
         s = m_store[i] + 1;
      end
      return m_store[NP-1] + 3;
   endfunction

   task automatic check_batch(input int ncyc, input int pulse_c);
      bit st_e, wr_e, err_e;
      int cnt_e, addr_e, zj, wi;
      for (int c = 0; c < ncyc; c++) begin
         run_i = (c == pulse_c);
         st_e = 0; wr_e = 0; err_e = 0; cnt_e = 0; addr_e = 0; zj = -1; wi = 0;
         for (int i = 0; i < NP; i++) begin
            if (m_st[i] == c) st_e = 1;
            if (m_store[i] == c) begin
               wr_e = 1;
               wi   = i;
            end
            if (m_store[i] < c) cnt_e++;
            if (m_to[i] && m_store[i] <= c) err_e = 1;
            if (m_ps[i] <= c) addr_e = i;
            if (m_ps[i] + 2 <= c) zj = i;
         end
         chk("start", c, int'(ggt_start_o), int'(st_e));
         chk("wren", c, int'(res_wren_o), int'(wr_e));
         if (wr_e) begin
            chk("res_addr", c, int'(res_addr_o), wi);
            chk("res_data", c, int'(res_data_o), m_data[wi]);
         end else if (c > m_store[NP-1]) begin
            chk("res_data_hold", c, int'(res_data_o), m_data[NP-1]);
         end
         chk("busy", c, int'(busy_o), int'(c <= m_store[NP-1]));
         chk("done", c, int'(done_o), int'(c > m_store[NP-1]));
         chk("count", c, int'(count_o), cnt_e);
         chk("error", c, int'(error_o), int'(err_e));
         chk("op_addr", c, int'(op_addr_o), addr_e);
         if (zj >= 0) begin
            chk("zahl1", c, int'(zahl1_o), int'(rom[zj][31:16]));
            chk("zahl2", c, int'(zahl2_o), int'(rom[zj][15:0]));
         end
         @(negedge clk);
      end
      run_i = 1'b0;
   endtask

   task automatic run_batch(input int pulse_c);
      int total;
      total = build_model();
      wr_q.delete();
      run_i = 1'b1;
      @(negedge clk);
      check_batch(total, pulse_c);
   endtask

   typedef int quad_t [4];
   task automatic chk_writes(input string nm, input quad_t e);
      chk({nm, "_nwrites"}, 0, wr_q.size(), 4);
      for (int i = 0; i < 4 && i < wr_q.size(); i++) chk({nm, "_write"}, i, wr_q[i], e[i]);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_op_addr"}, 0, int'(op_addr_o), 0);
      chk({nm, "_zahl"}, 0, int'(zahl1_o | zahl2_o), 0);
      chk({nm, "_start"}, 0, int'(ggt_start_o), 0);
      chk({nm, "_res_addr"}, 0, int'(res_addr_o), 0);
      chk({nm, "_res_data"}, 0, int'(res_data_o), 0);
      chk({nm, "_wren"}, 0, int'(res_wren_o), 0);
      chk({nm, "_busy"}, 0, int'(busy_o), 0);
      chk({nm, "_done"}, 0, int'(done_o), 0);
      chk({nm, "_error"}, 0, int'(error_o), 0);
      chk({nm, "_count"}, 0, int'(count_o), 0);
   endtask

   int s0;

   initial begin
      for (int i = 0; i < 8; i++) set_pair(i, 0, 0, 1, 1'b0, 1'b0);
      #1 rst_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_i = 1'b0;
      @(negedge clk);

      // A: plain gcd pairs with various latencies.
      set_pair(0, 180, 180, 3, 1'b0, 1'b0);
      set_pair(1, 24255, 12540, 5, 1'b0, 1'b0);
      set_pair(2, 48, 18, 2, 1'b0, 1'b0);
      set_pair(3, 17, 5, 1, 1'b0, 1'b0);
      s0 = n_starts;
      run_batch(-1);
      chk_writes("A", '{180, 165, 6, 1});
      chk("A_starts", 0, n_starts - s0, 4);
      chk("A_error", 0, int'(error_o), 0);

      // B: zero-operand bypass, then valid arriving exactly on the timeout cycle.
      set_pair(0, 0, 42, 1, 1'b0, 1'b0);
      set_pair(1, 0, 0, 1, 1'b0, 1'b0);
      set_pair(2, 7, 0, 1, 1'b0, 1'b0);
      set_pair(3, 35, 21, TMO - 1, 1'b0, 1'b0);
      s0 = n_starts;
      run_batch(-1);
      chk_writes("B", '{42, 0, 7, 7});
      chk("B_starts", 0, n_starts - s0, 1);
      chk("B_error", 0, int'(error_o), 0);

      // C: stuck valid, stale valid, late valid; run_i pulsed during the first WAIT.
      set_pair(0, 100, 75, 1, 1'b1, 1'b0);
      set_pair(1, 12, 8, 2, 1'b0, 1'b0);
      set_pair(2, 81, 27, 1, 1'b0, 1'b1);
      set_pair(3, 9, 6, TMO, 1'b0, 1'b0);
      s0 = n_starts;
      run_batch(5);
      chk_writes("C", '{0, 4, 27, 0});
      chk("C_starts", 0, n_starts - s0, 4);
      chk("C_error", 0, int'(error_o), 1);
      chk("C_count", 0, int'(count_o), 4);

      // D: reset in the middle of pair 1's WAIT, then a full rerun.
      set_pair(0, 180, 180, 3, 1'b0, 1'b0);
      set_pair(1, 24255, 12540, 5, 1'b0, 1'b0);
      set_pair(2, 48, 18, 2, 1'b0, 1'b0);
      set_pair(3, 17, 5, 1, 1'b0, 1'b0);
      void'(build_model());
      run_i = 1'b1;
      @(negedge clk);
      check_batch(13, -1);
      rst_i = 1'b1;
      #1;
      chk_all_zero("async_rst");
      wr_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_wren", i, int'(res_wren_o), 0);
         chk("rst_busy", i, int'(busy_o), 0);
      end
      chk("rst_nwrites", 0, wr_q.size(), 0);
      rst_i = 1'b0;
      @(negedge clk);
      run_batch(-1);
      chk_writes("D", '{180, 165, 6, 1});
      chk("D_count", 0, int'(count_o), 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
